// File: rtl/vp_pkg.sv
// Shared encodings for the VP colour-conversion frame controller.
// Holds the mode and state types plus the default frame geometry.
package vp_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GREY   = 2'd1,
        MODE_YCBCR  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    localparam int DEF_EXP_W = 640;
    localparam int DEF_EXP_H = 480;

    // The reserved encoding 3 folds onto bypass so the path mux never sees it.
    function automatic mode_t sanitize_mode(input logic [1:0] req);
        mode_t m;
        case (req)
            2'd1:    m = MODE_GREY;
            2'd2:    m = MODE_YCBCR;
            default: m = MODE_BYPASS;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vp_frame_ctrl_if.sv
// Bundle of video timing inputs, CPU-side configuration and per-frame status
// exchanged between the capture front end, register block and frame controller.
interface vp_frame_ctrl_if #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) ();

    logic              pre_frame_vsync;
    logic              pre_frame_hsync;
    logic              pre_frame_de;
    logic              cfg_en;
    logic [1:0]        cfg_mode;
    logic              cfg_wr;
    logic [1:0]        mode_active;
    logic              proc_en;
    logic              frame_done;
    logic              err_size;
    logic [H_BITS-1:0] meas_w;
    logic [V_BITS-1:0] meas_h;
    logic [15:0]       frame_cnt;

    modport master (
        output pre_frame_vsync,
        output pre_frame_hsync,
        output pre_frame_de,
        output cfg_en,
        output cfg_mode,
        output cfg_wr,
        input  mode_active,
        input  proc_en,
        input  frame_done,
        input  err_size,
        input  meas_w,
        input  meas_h,
        input  frame_cnt
    );

    modport slave (
        input  pre_frame_vsync,
        input  pre_frame_hsync,
        input  pre_frame_de,
        input  cfg_en,
        input  cfg_mode,
        input  cfg_wr,
        output mode_active,
        output proc_en,
        output frame_done,
        output err_size,
        output meas_w,
        output meas_h,
        output frame_cnt
    );

endinterface

// File: rtl/vp_edge_det.sv
// Registered edge detector: the input is sampled once and compared with its
// previous value to give single-cycle rise and fall strobes.
module vp_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_d;
    logic sig_q;

    always_comb begin
        sig_d = sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/vp_frame_ctrl.sv
// Frame-level controller for the VP colour-conversion path: applies mode
// changes on frame boundaries, gates processing and measures frame geometry.
module vp_frame_ctrl
    import vp_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int EXP_W  = DEF_EXP_W,
    parameter int EXP_H  = DEF_EXP_H
) (
    input  logic           clk,
    input  logic           rst_n,
    vp_frame_ctrl_if.slave vif
);

    localparam logic [H_BITS-1:0] PIX_MAX  = '1;
    localparam logic [V_BITS-1:0] LINE_MAX = '1;
    localparam logic [H_BITS-1:0] EXP_W_V  = H_BITS'(EXP_W);
    localparam logic [V_BITS-1:0] EXP_H_V  = V_BITS'(EXP_H);

    logic vs_rise;
    logic vs_fall;
    logic de_rise;
    logic de_fall;

    state_t            state_q,      state_d;
    mode_t             shadow_q,     shadow_d;
    mode_t             mode_q,       mode_d;
    logic              proc_en_q,    proc_en_d;
    logic              frame_done_q, frame_done_d;
    logic              err_size_q,   err_size_d;
    logic [H_BITS-1:0] meas_w_q,     meas_w_d;
    logic [V_BITS-1:0] meas_h_q,     meas_h_d;
    logic [15:0]       frame_cnt_q,  frame_cnt_d;
    logic [H_BITS-1:0] pix_cnt_q,    pix_cnt_d;
    logic [V_BITS-1:0] line_cnt_q,   line_cnt_d;
    logic [H_BITS-1:0] line_w_q,     line_w_d;
    logic              line_mis_q,   line_mis_d;

    logic [H_BITS-1:0] pix_nx;
    logic [V_BITS-1:0] line_cnt_nx;
    logic [H_BITS-1:0] line_w_nx;
    logic              line_mis_nx;

    // Lines are delimited by de alone; hsync is carried for completeness only.
    logic hsync_unused;
    assign hsync_unused = vif.pre_frame_hsync;

    vp_edge_det u_vs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vif.pre_frame_vsync),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    vp_edge_det u_de_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vif.pre_frame_de),
        .rise  (de_rise),
        .fall  (de_fall)
    );

    logic edge_unused;
    assign edge_unused = vs_fall | de_rise;

    // Geometry after this cycle, including a line that closes on the same
    // cycle as vs_rise, so the frame-close values see every finished line.
    always_comb begin
        pix_nx      = pix_cnt_q;
        line_cnt_nx = line_cnt_q;
        line_w_nx   = line_w_q;
        line_mis_nx = line_mis_q;

        if (vif.pre_frame_de && (pix_cnt_q != PIX_MAX)) begin
            pix_nx = pix_cnt_q + 1'b1;
        end

        if (de_fall) begin
            pix_nx = '0;
            if (line_cnt_q != LINE_MAX) begin
                line_cnt_nx = line_cnt_q + 1'b1;
            end
            if (line_cnt_q == '0) begin
                line_w_nx = pix_cnt_q;
            end else if (pix_cnt_q != line_w_q) begin
                line_mis_nx = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        mode_d       = mode_q;
        proc_en_d    = proc_en_q;
        frame_done_d = 1'b0;
        err_size_d   = 1'b0;
        meas_w_d     = meas_w_q;
        meas_h_d     = meas_h_q;
        frame_cnt_d  = frame_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        line_w_d     = line_w_q;
        line_mis_d   = line_mis_q;

        if (vif.cfg_wr) begin
            shadow_d = sanitize_mode(vif.cfg_mode);
        end

        case (state_q)
            ST_IDLE: begin
                proc_en_d = 1'b0;
                if (vif.cfg_en) begin
                    state_d = ST_WAIT_VS;
                end
            end

            ST_WAIT_VS: begin
                if (!vif.cfg_en) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    state_d    = ST_ACTIVE;
                    mode_d     = shadow_q;
                    proc_en_d  = 1'b1;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    line_w_d   = '0;
                    line_mis_d = 1'b0;
                end
            end

            ST_ACTIVE: begin
                pix_cnt_d  = pix_nx;
                line_cnt_d = line_cnt_nx;
                line_w_d   = line_w_nx;
                line_mis_d = line_mis_nx;

                // cfg_en is only honoured here, so a disable waits for the frame end.
                if (vs_rise) begin
                    meas_w_d     = line_w_nx;
                    meas_h_d     = line_cnt_nx;
                    frame_done_d = 1'b1;
                    err_size_d   = line_mis_nx
                                 | (line_w_nx != EXP_W_V)
                                 | (line_cnt_nx != EXP_H_V);
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    pix_cnt_d    = '0;
                    line_cnt_d   = '0;
                    line_w_d     = '0;
                    line_mis_d   = 1'b0;
                    if (vif.cfg_en) begin
                        mode_d = shadow_q;
                    end else begin
                        state_d   = ST_IDLE;
                        proc_en_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                proc_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= MODE_BYPASS;
            mode_q       <= MODE_BYPASS;
            proc_en_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_size_q   <= 1'b0;
            meas_w_q     <= '0;
            meas_h_q     <= '0;
            frame_cnt_q  <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            line_w_q     <= '0;
            line_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            mode_q       <= mode_d;
            proc_en_q    <= proc_en_d;
            frame_done_q <= frame_done_d;
            err_size_q   <= err_size_d;
            meas_w_q     <= meas_w_d;
            meas_h_q     <= meas_h_d;
            frame_cnt_q  <= frame_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            line_w_q     <= line_w_d;
            line_mis_q   <= line_mis_d;
        end
    end

    assign vif.mode_active = mode_q;
    assign vif.proc_en     = proc_en_q;
    assign vif.frame_done  = frame_done_q;
    assign vif.err_size    = err_size_q;
    assign vif.meas_w      = meas_w_q;
    assign vif.meas_h      = meas_h_q;
    assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// Self-checking bench for vp_frame_ctrl with a small 4x3 frame geometry;
// closed-frame expectations are queued as frames are driven and popped on frame_done.
module tb_vp_frame_ctrl;

    localparam int H_BITS = 12;
    localparam int V_BITS = 12;

    typedef struct {
        int w;
        int h;
        int err;
        int cnt;
        int mode;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;
    exp_t sb[$];

    vp_frame_ctrl_if #(.H_BITS(H_BITS), .V_BITS(V_BITS)) vif ();

    vp_frame_ctrl #(
        .H_BITS (H_BITS),
        .V_BITS (V_BITS),
        .EXP_W  (4),
        .EXP_H  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: every frame_done pops and checks one queued frame.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (vif.frame_done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got frame_done=1 frame_cnt=%0d, required no pulse", vif.frame_cnt);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (vif.meas_w !== H_BITS'(e.w)) begin
                        n_fail++;
                        $display("FAIL meas_w: got %0d, required %0d", vif.meas_w, e.w);
                    end
                    n_checks++;
                    if (vif.meas_h !== V_BITS'(e.h)) begin
                        n_fail++;
                        $display("FAIL meas_h: got %0d, required %0d", vif.meas_h, e.h);
                    end
                    n_checks++;
                    if (vif.err_size !== 1'(e.err)) begin
                        n_fail++;
                        $display("FAIL err_size: got %0d, required %0d", vif.err_size, e.err);
                    end
                    n_checks++;
                    if (vif.frame_cnt !== 16'(e.cnt)) begin
                        n_fail++;
                        $display("FAIL frame_cnt: got %0d, required %0d", vif.frame_cnt, e.cnt);
                    end
                    n_checks++;
                    if (vif.mode_active !== 2'(e.mode)) begin
                        n_fail++;
                        $display("FAIL mode_at_close: got %0d, required %0d", vif.mode_active, e.mode);
                    end
                end
            end else if (vif.err_size) begin
                n_checks++;
                n_fail++;
                $display("FAIL err_size_alone: got err_size=1 with frame_done=0, required 0");
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_wr(input logic [1:0] m);
        vif.cfg_mode = m;
        vif.cfg_wr   = 1'b1;
        tick(1);
        vif.cfg_wr   = 1'b0;
    endtask

    task automatic vs_pulse();
        vif.pre_frame_vsync = 1'b1;
        tick(2);
        vif.pre_frame_vsync = 1'b0;
        tick(2);
    endtask

    task automatic drive_line(input int npix, input int wr_at, input logic [1:0] wr_mode);
        vif.pre_frame_hsync = 1'b0;
        vif.pre_frame_de    = 1'b1;
        for (int i = 0; i < npix; i++) begin
            if (i == wr_at) begin
                vif.cfg_mode = wr_mode;
                vif.cfg_wr   = 1'b1;
            end
            tick(1);
            vif.cfg_wr = 1'b0;
        end
        vif.pre_frame_de    = 1'b0;
        vif.pre_frame_hsync = 1'b1;
        tick(3);
        vif.pre_frame_hsync = 1'b0;
    endtask

    task automatic push_exp(input int w, input int h, input int err, input int mode);
        exp_t e;
        exp_cnt = (exp_cnt + 1) % 65536;
        e.w = w; e.h = h; e.err = err; e.cnt = exp_cnt; e.mode = mode;
        sb.push_back(e);
    endtask

    task automatic close_frame(input string name);
        vs_pulse();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_done_seen: got %0d frames still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if ({vif.mode_active, vif.proc_en, vif.frame_done, vif.err_size} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got mode=%0d proc_en=%0d done=%0d err=%0d, required all 0",
                     vif.mode_active, vif.proc_en, vif.frame_done, vif.err_size);
        end
        n_checks++;
        if (vif.meas_w !== '0 || vif.meas_h !== '0 || vif.frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status: got w=%0d h=%0d cnt=%0d, required 0 0 0",
                     vif.meas_w, vif.meas_h, vif.frame_cnt);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_nominal();
        pulse_wr(2'd2);
        vif.cfg_en = 1'b1;
        tick(2);
        n_checks++;
        if (vif.proc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_vs_proc_en: got %0d, required 0", vif.proc_en);
        end
        vs_pulse();
        n_checks++;
        if (vif.proc_en !== 1'b1 || vif.mode_active !== 2'd2) begin
            n_fail++;
            $display("FAIL frame_start: got proc_en=%0d mode=%0d, required 1 2", vif.proc_en, vif.mode_active);
        end
        for (int l = 0; l < 3; l++) drive_line(4, -1, 2'd0);
        push_exp(4, 3, 0, 2);
        close_frame("nominal");
    endtask

    task automatic test_mode_change();
        drive_line(4, -1, 2'd0);
        drive_line(4, 1, 2'd1);
        n_checks++;
        if (vif.mode_active !== 2'd2) begin
            n_fail++;
            $display("FAIL mode_mid_frame: got %0d, required 2", vif.mode_active);
        end
        drive_line(4, -1, 2'd0);
        push_exp(4, 3, 0, 1);
        close_frame("mode_change");
    endtask

    task automatic test_reserved_ragged();
        drive_line(4, 2, 2'd3);
        drive_line(3, -1, 2'd0);
        drive_line(4, -1, 2'd0);
        push_exp(4, 3, 1, 0);
        close_frame("ragged");
        n_checks++;
        if (vif.mode_active !== 2'd0) begin
            n_fail++;
            $display("FAIL reserved_mode: got %0d, required 0", vif.mode_active);
        end
    endtask

    task automatic test_zero_lines();
        push_exp(0, 0, 1, 0);
        close_frame("zero_lines");
    endtask

    task automatic test_graceful_disable();
        pulse_wr(2'd2);
        drive_line(4, -1, 2'd0);
        drive_line(4, -1, 2'd0);
        vif.cfg_en = 1'b0;
        tick(2);
        n_checks++;
        if (vif.proc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_deferred: got proc_en=%0d, required 1", vif.proc_en);
        end
        drive_line(4, -1, 2'd0);
        push_exp(4, 3, 0, 0);
        close_frame("disable");
        n_checks++;
        if (vif.proc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_proc_en: got %0d, required 0", vif.proc_en);
        end
        vs_pulse();
        for (int l = 0; l < 3; l++) drive_line(4, -1, 2'd0);
        vs_pulse();
        n_checks++;
        if (vif.frame_cnt !== 16'(exp_cnt) || vif.proc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_frozen: got cnt=%0d proc_en=%0d, required %0d 0",
                     vif.frame_cnt, vif.proc_en, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        vif.cfg_en = 1'b1;
        tick(2);
        vs_pulse();
        n_checks++;
        if (vif.proc_en !== 1'b1 || vif.mode_active !== 2'd2) begin
            n_fail++;
            $display("FAIL restart: got proc_en=%0d mode=%0d, required 1 2", vif.proc_en, vif.mode_active);
        end
        vif.pre_frame_de = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (vif.proc_en !== 1'b0 || vif.mode_active !== 2'd0 || vif.frame_cnt !== 16'd0 || vif.meas_w !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got proc_en=%0d mode=%0d cnt=%0d w=%0d, required 0 0 0 0",
                     vif.proc_en, vif.mode_active, vif.frame_cnt, vif.meas_w);
        end
        exp_cnt = 0;
        vif.pre_frame_de = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        drive_line(4, -1, 2'd0);
        n_checks++;
        if (vif.proc_en !== 1'b0 || vif.frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_wait: got proc_en=%0d cnt=%0d, required 0 0", vif.proc_en, vif.frame_cnt);
        end
        vs_pulse();
        n_checks++;
        if (vif.proc_en !== 1'b1 || vif.mode_active !== 2'd0) begin
            n_fail++;
            $display("FAIL post_reset_start: got proc_en=%0d mode=%0d, required 1 0", vif.proc_en, vif.mode_active);
        end
        for (int l = 0; l < 3; l++) drive_line(4, -1, 2'd0);
        push_exp(4, 3, 0, 0);
        close_frame("post_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst_n    = 1'b0;
        vif.pre_frame_vsync = 1'b0;
        vif.pre_frame_hsync = 1'b0;
        vif.pre_frame_de    = 1'b0;
        vif.cfg_en          = 1'b0;
        vif.cfg_mode        = 2'd0;
        vif.cfg_wr          = 1'b0;

        test_reset();
        test_nominal();
        test_mode_change();
        test_reserved_ragged();
        test_zero_lines();
        test_graceful_disable();
        test_reset_mid_frame();

        tick(5);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d pending frames, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
